gate_sweep_checker: RTL and testbench

Self-checking stimulus and response stage for the team's 2-input primitive gates (AND/OR/NAND/NOR/XOR/XNOR). The block drives the gate's `a`/`b` inputs through all four input combinations, holds each combination for a programmable number of cycles, and samples the gate's `y` output. It compares each sample against the expected function and reports per-vector pass/fail. It sits directly around a gate instance: upstream of the gate's inputs and downstream of its output. It replaces hand-written truth-table benches with a synthesizable built-in self-test.

---
 rtl/gate_sweep_pkg.sv | 35 +++
 rtl/gate_sweep_checker.sv | 127 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: op encodings, FSM states and
// the reference truth function for the supported 2-input primitives.
package gate_sweep_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NAND  = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_BUF_A = 3'd6;
  localparam logic [2:0] OP_NOT_A = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic expected_y(input logic [2:0] op, input logic a, input logic b);
    logic v;
    case (op)
      OP_AND:   v = a & b;
      OP_OR:    v = a | b;
      OP_NAND:  v = ~(a & b);
      OP_NOR:   v = ~(a | b);
      OP_XOR:   v = a ^ b;
      OP_XNOR:  v = ~(a ^ b);
      OP_BUF_A: v = a;
      default:  v = ~a;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Built-in self-test around a 2-input gate: walks {a,b} through 00..11, holds
// each vector HOLD_CYCLES cycles, samples y on the last hold cycle and scores it.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; a/b parked at 0, results held
//   RUN     | applying vector idx, counting hold cycles, sampling y
//   DONE    | one-cycle done pulse; results valid, returns to IDLE
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] fail_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_op;
  logic [1:0]      r_idx;
  logic [HW-1:0]   r_hold;
  logic [3:0]      r_mask;
  logic [2:0]      r_cnt;
  logic            r_pass;

  logic            w_accept;
  logic            w_sample;
  logic            w_last;
  logic            w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_hold == HOLD_LAST) begin
          w_sample = 1'b1;
          if (r_idx == 2'd3) begin
            w_last      = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_mismatch = (y != expected_y(r_op, r_idx[1], r_idx[0]));

  // idx wraps back to 0 on the final sample, so it also parks a/b at 00
  // in IDLE and DONE without any extra gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op   <= '0;
      r_idx  <= '0;
      r_hold <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_op   <= op;
      r_idx  <= '0;
      r_hold <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_sample) begin
        r_hold <= '0;
        r_idx  <= r_idx + 2'd1;
        if (w_mismatch) begin
          r_mask[r_idx] <= 1'b1;
          r_cnt         <= r_cnt + 3'd1;
        end
        if (w_last) begin
          r_pass <= (r_cnt == 3'd0) && !w_mismatch;
        end
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign a          = r_idx[1];
  assign b          = r_idx[0];
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign pass       = r_pass;
  assign fail_mask  = r_mask;
  assign fail_count = r_cnt;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: two checker instances (hold 4 and hold 1) each wrapped
// around a truth-table gate model, scored against a truth-table reference.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op  = 3'd0;
  logic       start_s [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       y_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] mask_s  [2];
  logic [2:0] cnt_s   [2];
  logic [3:0] gtt     [2];
  int         hold_of [2] = '{4, 1};

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Gate under test: y looked up from a truth table indexed by {a,b}.
  // gtt = 4'b1110 is the or_gate; 4'b1111 / 4'b0000 model stuck outputs.
  assign y_s[0] = gtt[0][{a_s[0], b_s[0]}];
  assign y_s[1] = gtt[1][{a_s[1], b_s[1]}];

  gate_sweep_checker #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start_s[0]), .op(op),
    .a(a_s[0]), .b(b_s[0]), .y(y_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .fail_mask(mask_s[0]), .fail_count(cnt_s[0])
  );

  gate_sweep_checker #(.HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .op(op),
    .a(a_s[1]), .b(b_s[1]), .y(y_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .fail_mask(mask_s[1]), .fail_count(cnt_s[1])
  );

  // Truth table of each op, bit {a,b} = expected y.
  function automatic logic [3:0] op_tt(input logic [2:0] o);
    case (o)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input int s, input string tag);
    check({tag, "_ab"},   {6'd0, a_s[s], b_s[s]}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy_s[s]},      8'd0);
    check({tag, "_done"}, {7'd0, done_s[s]},      8'd0);
    check({tag, "_pass"}, {7'd0, pass_s[s]},      8'd0);
    check({tag, "_mask"}, {4'd0, mask_s[s]},      8'd0);
    check({tag, "_cnt"},  {5'd0, cnt_s[s]},       8'd0);
  endtask

  // One complete sweep on instance s with full cycle-by-cycle sequence checks.
  task automatic run(input int s, input logic [2:0] opv, input logic [3:0] g,
                     input int pulse_at, input string tag);
    int         h;
    logic [3:0] exp_mask;
    h         = hold_of[s];
    gtt[s]    = g;
    op        = opv;
    start_s[s] = 1'b1;
    tick();                                // now just after E0
    start_s[s] = 1'b0;
    op        = 3'($urandom_range(0, 7));  // must not disturb the captured op
    exp_mask  = op_tt(opv) ^ g;
    for (int c = 0; c < 4 * h; c++) begin
      check({tag, "_busy"}, {7'd0, busy_s[s]}, 8'd1);
      check({tag, "_done_early"}, {7'd0, done_s[s]}, 8'd0);
      check({tag, "_ab"}, {6'd0, a_s[s], b_s[s]}, 8'(c / h));
      if (c == pulse_at) start_s[s] = 1'b1;
      tick();
      start_s[s] = 1'b0;
    end
    check({tag, "_done"},     {7'd0, done_s[s]}, 8'd1);
    check({tag, "_busy_end"}, {7'd0, busy_s[s]}, 8'd0);
    check({tag, "_ab_end"},   {6'd0, a_s[s], b_s[s]}, 8'd0);
    check({tag, "_mask"},     {4'd0, mask_s[s]}, {4'd0, exp_mask});
    check({tag, "_cnt"},      {5'd0, cnt_s[s]}, 8'($countones(exp_mask)));
    check({tag, "_pass"},     {7'd0, pass_s[s]}, {7'd0, exp_mask == 4'd0});
    tick();
    check({tag, "_done_drop"}, {7'd0, done_s[s]}, 8'd0);
    check({tag, "_idle_busy"}, {7'd0, busy_s[s]}, 8'd0);
    check({tag, "_pass_hold"}, {7'd0, pass_s[s]}, {7'd0, exp_mask == 4'd0});
  endtask

  initial begin
    int   n;
    logic seen_done;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    gtt[0] = 4'b1110;
    gtt[1] = 4'b1110;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs(0, "rst_h4");
    check_reset_outputs(1, "rst_h1");

    run(0, 3'd1, 4'b1110, -1, "or_pass");
    run(0, 3'd0, 4'b1110, -1, "wrong_op");
    run(0, 3'd2, 4'b1111, -1, "stuck1_nand");
    run(0, 3'd4, 4'b0000, -1, "stuck0_xor");
    run(0, 3'd1, 4'b1110,  5, "start_pulse");
    run(1, 3'd1, 4'b1110, -1, "h1_or_pass");
    run(1, 3'd5, 4'b1110,  2, "h1_wrong");

    // start held high: the next run must be accepted right after done and clear results
    gtt[0] = 4'b1110;
    op = 3'd0;
    start_s[0] = 1'b1;
    n = 0;
    while (done_s[0] !== 1'b1 && n < 40) begin tick(); n++; end
    check("held_done_seen", {7'd0, done_s[0]}, 8'd1);
    check("held_mask1", {4'd0, mask_s[0]}, 8'h06);
    op = 3'd1;
    n = 0;
    while (busy_s[0] !== 1'b1 && n < 3) begin tick(); n++; end
    check("held_rerun_busy", {7'd0, busy_s[0]}, 8'd1);
    check("held_rerun_mask_clr", {4'd0, mask_s[0]}, 8'd0);
    check("held_rerun_cnt_clr", {5'd0, cnt_s[0]}, 8'd0);
    start_s[0] = 1'b0;
    n = 0;
    while (done_s[0] !== 1'b1 && n < 40) begin tick(); n++; end
    check("held_rerun_done", {7'd0, done_s[0]}, 8'd1);
    check("held_rerun_pass", {7'd0, pass_s[0]}, 8'd1);
    tick();

    // reset in the middle of a run with a failing configuration
    op = 3'd0;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs(0, "midrst");
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done_s[0] === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("midrst_no_done", {7'd0, seen_done}, 8'd0);
    run(0, 3'd3, 4'b0001, -1, "post_rst_nor");

    // randomized sweeps on both instances against the truth-table model
    for (int i = 0; i < 24; i++) begin
      run(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), -1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
